// File: rtl/dbg_mem_responder_pkg.sv
// Shared types and sizes for the debug memory-read responder.
package debug_pkg;
  localparam int DBG_A_WIDTH  = 10;
  localparam int DBG_D_WIDTH  = 12;
  localparam int DBG_WAIT_MAX = 15;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} dbg_state_e;

  typedef struct packed {
    logic                   refused;
    logic [DBG_D_WIDTH-1:0] dmem_out;
  } debug_packet_s;
endpackage

// File: rtl/dbg_mem_responder_if.sv
// Debug request, core arbitration and data-memory port signals of the responder.
interface dbg_mem_responder_if
  import debug_pkg::*;
#(
  parameter int A_WIDTH = DBG_A_WIDTH,
  parameter int D_WIDTH = DBG_D_WIDTH
);
  logic               tb_mem_read_i;
  logic [A_WIDTH-1:0] tb_addr_i;
  logic               core_mem_req_i;
  logic               core_halted_i;
  logic               mem_ready_i;
  logic [D_WIDTH-1:0] mem_data_i;
  logic               mem_sel_o;
  logic               mem_req_o;
  logic [A_WIDTH-1:0] mem_addr_o;
  logic               dbg_busy_o;
  logic [D_WIDTH-1:0] dmem_out_o;
  logic               dbg_valid_o;
  logic               refused_o;

  modport slave (
    input  tb_mem_read_i, tb_addr_i, core_mem_req_i, core_halted_i, mem_ready_i, mem_data_i,
    output mem_sel_o, mem_req_o, mem_addr_o, dbg_busy_o, dmem_out_o, dbg_valid_o, refused_o
  );

  modport master (
    output tb_mem_read_i, tb_addr_i, core_mem_req_i, core_halted_i, mem_ready_i, mem_data_i,
    input  mem_sel_o, mem_req_o, mem_addr_o, dbg_busy_o, dmem_out_o, dbg_valid_o, refused_o
  );
endinterface

// File: rtl/dbg_mem_responder_timeout_ctr.sv
// Cycle counter for the WAIT state; expired is high once WAIT_MAX cycles have gone by.
module dbg_timeout_ctr #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(WAIT_MAX));

  // Holds at WAIT_MAX so a late enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (clr)              cnt_q <= '0;
    else if (en && !expired)   cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/dbg_mem_responder.sv
// Debug memory-read responder: arbitrates the data-memory port against the core.
// Optional refusal counter output refuse_cnt_o under macro DBG_REFUSE_CNT_EN.
//
// state | meaning
// IDLE  | core owns the port; debug request sampled here
// ISSUE | debug owns the port, read strobe to memory
// WAIT  | debug owns the port, waiting for mem_ready_i or timeout
// RESP  | port released, dbg_valid_o pulse
module dbg_mem_responder
  import debug_pkg::*;
#(
  parameter int A_WIDTH  = DBG_A_WIDTH,
  parameter int D_WIDTH  = DBG_D_WIDTH,
  parameter int WAIT_MAX = DBG_WAIT_MAX
) (
  input  logic                 clk,
  input  logic                 reset_i,
  dbg_mem_responder_if.slave   bus
`ifdef DBG_REFUSE_CNT_EN
  ,
  output logic [15:0]          refuse_cnt_o
`endif
);
  dbg_state_e         state_q, state_d;
  logic [A_WIDTH-1:0] addr_q;
  logic [D_WIDTH-1:0] dout_q;
  logic               refused_q, refused_d;
  logic               latch, capture, expired, ctr_clr, ctr_en;
  logic               sel, req, busy, valid;
  debug_packet_s      pkt;

  dbg_timeout_ctr #(.WAIT_MAX(WAIT_MAX)) u_timeout (
    .clk     (clk),
    .rst_n   (reset_i),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      dout_q    <= '0;
      refused_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      refused_q <= refused_d;
      if (latch)   addr_q <= bus.tb_addr_i;
      if (capture) dout_q <= bus.mem_data_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    refused_d = 1'b0;
    latch     = 1'b0;
    capture   = 1'b0;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    sel       = 1'b0;
    req       = 1'b0;
    busy      = 1'b0;
    valid     = 1'b0;
    case (state_q)
      IDLE: begin
        // A running core keeps the port; a halted core yields it.
        if (bus.tb_mem_read_i) begin
          if (bus.core_mem_req_i && !bus.core_halted_i) begin
            refused_d = 1'b1;
          end else begin
            latch   = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        sel     = 1'b1;
        req     = 1'b1;
        busy    = 1'b1;
        ctr_clr = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        sel  = 1'b1;
        busy = 1'b1;
        if (bus.mem_ready_i) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (expired) begin
          refused_d = 1'b1;
          state_d   = IDLE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      RESP: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pkt.refused  = refused_q;
  assign pkt.dmem_out = dout_q;

  assign bus.mem_sel_o   = sel;
  assign bus.mem_req_o   = req;
  assign bus.mem_addr_o  = addr_q;
  assign bus.dbg_busy_o  = busy;
  assign bus.dbg_valid_o = valid;
  assign bus.refused_o   = pkt.refused;
  assign bus.dmem_out_o  = pkt.dmem_out;

`ifdef DBG_REFUSE_CNT_EN
  logic [15:0] refuse_cnt_q;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i)                                  refuse_cnt_q <= '0;
    else if (refused_d && refuse_cnt_q != 16'hFFFF) refuse_cnt_q <= refuse_cnt_q + 16'd1;
  end

  assign refuse_cnt_o = refuse_cnt_q;
`endif
endmodule

// File: tb/tb_dbg_mem_responder.sv
// Randomized bench for dbg_mem_responder with a transaction-level timing model.
module tb_dbg_mem_responder;
  import debug_pkg::*;

  localparam int AW = DBG_A_WIDTH;
  localparam int DW = DBG_D_WIDTH;
  localparam int WM = DBG_WAIT_MAX;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  dbg_mem_responder_if bus ();

`ifdef DBG_REFUSE_CNT_EN
  logic [15:0] refuse_cnt;
  dbg_mem_responder dut (.clk(clk), .reset_i(reset_i), .bus(bus), .refuse_cnt_o(refuse_cnt));
`else
  dbg_mem_responder dut (.clk(clk), .reset_i(reset_i), .bus(bus));
`endif

  int tests = 0;
  int fails = 0;

  // Expected outputs for the current cycle, written by the driver from timing rules.
  logic          e_sel, e_req, e_busy, e_valid, e_ref;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_dout;
  int            exp_refusals;
  logic          chk_en = 1'b0;
  logic [DW-1:0] junk;

  int n_valid = 0, n_refused = 0, busy_run = 0, last_busy_run = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return DW'(a) ^ 12'hA5A;
  endfunction

  assign bus.mem_data_i = bus.mem_ready_i ? mem_word(bus.mem_addr_o) : junk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_sel", bus.mem_sel_o, e_sel);
      chk("mem_req", bus.mem_req_o, e_req);
      chk("dbg_busy", bus.dbg_busy_o, e_busy);
      chk("dbg_valid", bus.dbg_valid_o, e_valid);
      chk("refused", bus.refused_o, e_ref);
      chk("dmem_out", bus.dmem_out_o, e_dout);
      if (e_req) chk("mem_addr", bus.mem_addr_o, e_addr);
`ifdef DBG_REFUSE_CNT_EN
      chk("refuse_cnt", refuse_cnt, exp_refusals);
`endif
    end
    if (bus.dbg_valid_o) n_valid++;
    if (bus.refused_o) n_refused++;
    if (bus.dbg_busy_o) busy_run++;
    else begin
      if (busy_run != 0) last_busy_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_sel = 1'b0; e_req = 1'b0; e_busy = 1'b0; e_valid = 1'b0; e_ref = 1'b0;
  endtask

  // Starts in an idle cycle; k = WAIT cycle index carrying mem_ready_i, k > WM means never.
  task automatic txn(input logic [AW-1:0] addr, input bit core_req, input bit halted,
                     input int k, input bit noise);
    bus.tb_mem_read_i  = 1'b1;
    bus.tb_addr_i      = addr;
    bus.core_mem_req_i = core_req;
    bus.core_halted_i  = halted;
    bus.mem_ready_i    = noise ? 1'($urandom) : 1'b0;
    junk = DW'($urandom);
    step();
    set_idle();
    if (core_req && !halted) begin
      e_ref = 1'b1;
      exp_refusals++;
      bus.tb_mem_read_i  = 1'b0;
      bus.core_mem_req_i = 1'b0;
    end else begin
      e_sel = 1'b1; e_req = 1'b1; e_busy = 1'b1; e_addr = addr;
      bus.tb_mem_read_i  = 1'($urandom);
      bus.tb_addr_i      = AW'($urandom);
      bus.core_mem_req_i = 1'($urandom);
      bus.mem_ready_i    = noise ? 1'($urandom) : 1'b0;
      for (int j = 0; j <= WM; j++) begin
        step();
        set_idle();
        e_sel = 1'b1; e_busy = 1'b1;
        bus.mem_ready_i    = (j == k);
        bus.core_mem_req_i = 1'($urandom);
        bus.tb_addr_i      = AW'($urandom);
        junk = DW'($urandom);
        if (j == k) break;
      end
      step();
      set_idle();
      if (k <= WM) begin
        e_valid = 1'b1;
        e_dout  = mem_word(addr);
      end else begin
        e_ref = 1'b1;
        exp_refusals++;
      end
      bus.tb_mem_read_i  = 1'b0;
      bus.core_mem_req_i = 1'b0;
      bus.mem_ready_i    = noise ? 1'($urandom) : 1'b0;
    end
    step();
    set_idle();
    bus.mem_ready_i = 1'b0;
  endtask

  task automatic apply_reset();
    reset_i = 1'b0;
    set_idle();
    e_dout = '0;
    exp_refusals = 0;
    step();
    step();
    reset_i = 1'b1;
  endtask

  int v0, r0;

  initial begin
    bus.tb_mem_read_i  = 1'b0;
    bus.tb_addr_i      = '0;
    bus.core_mem_req_i = 1'b0;
    bus.core_halted_i  = 1'b0;
    bus.mem_ready_i    = 1'b0;
    junk = '0;
    set_idle();
    e_addr = '0;
    e_dout = '0;
    exp_refusals = 0;
    #1 chk_en = 1'b1;
    apply_reset();
    step();

    // Halted dump of the full address range, ready one cycle after the strobe.
    v0 = n_valid; r0 = n_refused;
    for (int a = 0; a < 1024; a++) begin
      txn(AW'(a), 1'($urandom), 1'b1, 0, 1'b1);
      if (a == 0)    chk("dump_addr0_data", bus.dmem_out_o, 12'hA5A);
      if (a == 1023) chk("dump_addr3ff_data", bus.dmem_out_o, 12'h9A5);
    end
    chk("dump_valid_pulses", n_valid - v0, 1024);
    chk("dump_refusals", n_refused - r0, 0);
    chk("min_busy_len", last_busy_run, 2);

    // Contention with a running core.
    r0 = n_refused;
    txn(10'h010, 1'b1, 1'b0, 0, 1'b0);
    chk("contention_refusal", n_refused - r0, 1);
    chk("contention_dout_held", bus.dmem_out_o, 12'h9A5);

    // Timeout: ISSUE plus WAIT_MAX+1 WAIT cycles of busy, then refusal.
    r0 = n_refused;
    txn(10'h123, 1'b0, 1'b0, WM + 1, 1'b0);
    chk("timeout_refusal", n_refused - r0, 1);
    chk("timeout_busy_len", last_busy_run, 17);
    chk("timeout_dout_held", bus.dmem_out_o, 12'h9A5);

    // Stall: core raises its request during WAIT; ready arrives late.
    txn(10'h3FF, 1'b0, 1'b0, 3, 1'b1);
    chk("stall_read_3ff", bus.dmem_out_o, 12'h9A5);
    chk("stall_busy_len", last_busy_run, 5);
    txn(10'h0F0, 1'b0, 1'b1, WM, 1'b0);
    chk("last_wait_ready", bus.dmem_out_o, 12'hAAA);

    // Asynchronous reset in the middle of WAIT.
    bus.tb_mem_read_i = 1'b1; bus.tb_addr_i = 10'h055; bus.core_halted_i = 1'b1;
    step();
    set_idle(); e_sel = 1'b1; e_req = 1'b1; e_busy = 1'b1; e_addr = 10'h055;
    bus.tb_mem_read_i = 1'b0;
    step();
    set_idle(); e_sel = 1'b1; e_busy = 1'b1;
    #2;
    reset_i = 1'b0;
    set_idle();
    e_dout = '0;
    exp_refusals = 0;
    #1;
    chk("rst_mem_sel", bus.mem_sel_o, 1'b0);
    chk("rst_busy", bus.dbg_busy_o, 1'b0);
    chk("rst_dout", bus.dmem_out_o, 12'h000);
    chk("rst_refused", bus.refused_o, 1'b0);
    bus.mem_ready_i = 1'b1;
    step();
    reset_i = 1'b1;
    v0 = n_valid;
    for (int i = 0; i < 4; i++) step();
    bus.mem_ready_i = 1'b0;
    chk("rst_no_valid_after", n_valid - v0, 0);
    step();

`ifdef DBG_REFUSE_CNT_EN
    for (int i = 0; i < 3; i++) txn(10'h010, 1'b1, 1'b0, 0, 1'b0);
    chk("refuse_cnt_three", refuse_cnt, 16'd3);
    apply_reset();
    step();
    chk("refuse_cnt_reset", refuse_cnt, 16'd0);
`endif

    // Randomized mix of grants, refusals and timeouts.
    for (int t = 0; t < 300; t++) begin
      int k;
      k = ($urandom_range(0, 5) == 0) ? WM + 1 : int'($urandom_range(0, WM));
      txn(AW'($urandom), 1'($urandom), 1'($urandom), k, 1'($urandom));
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        bus.mem_ready_i = 1'($urandom);
        step();
        bus.mem_ready_i = 1'b0;
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
